// File: rtl/spi_slave_ctrl_pkg.sv
// Shared types and constants for the SPI slave front end of the single-port RAM.
package spi_slave_ctrl_pkg;

    localparam int SPI_DATA_W  = 8;
    localparam int SPI_FRAME_W = SPI_DATA_W + 2;

    // Command codes carried in frame bits [9:8]
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    // True in the states that shift in the payload bits of a frame
    function automatic logic is_frame_state(input state_e s);
        return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
    endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Serial pins plus the RAM-side frame/read-data handshake of the SPI slave.
interface spi_slave_ctrl_if
    import spi_slave_ctrl_pkg::*;
#(
    parameter int FRAME_W = SPI_FRAME_W,
    parameter int DATA_W  = SPI_DATA_W
);
    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_slave_ctrl_tx_serializer.sv
// Parallel-in/serial-out stage that shifts one RAM read byte onto MISO, MSB first.
module spi_slave_ctrl_tx_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
    output logic              busy
);
    localparam logic [2:0] CNT_LAST = 3'(DATA_W - 1);

    logic [DATA_W-1:0] shift;
    logic [2:0]        cnt;

    // Window control: MISO shows the MSB right after the load edge, then one bit per cycle
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            busy <= 1'b0;
            miso <= 1'b0;
            cnt  <= '0;
        end else if (busy) begin
            if (cnt == CNT_LAST) begin
                busy <= 1'b0;
                miso <= 1'b0;
                cnt  <= '0;
            end else begin
                miso <= shift[DATA_W-1];
                cnt  <= cnt + 3'd1;
            end
        end else if (load) begin
            busy <= 1'b1;
            miso <= tx_data[DATA_W-1];
            cnt  <= '0;
        end
    end

    // Data shifter holds the bits still to be sent; the MSB already left at load time
    always_ff @(posedge clk) begin
        if (load && !busy) begin
            shift <= {tx_data[DATA_W-2:0], 1'b0};
        end else if (busy) begin
            shift <= shift << 1;
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises 10-bit command frames for the RAM and
// serialises the RAM read byte back onto MISO after a read-data frame.
module spi_slave_ctrl
    import spi_slave_ctrl_pkg::*;
#(
    parameter int FRAME_W = SPI_FRAME_W,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    spi_slave_ctrl_if.slave  bus
);
    // Counter value while the last bit (bit 0) is sampled, and the saturated "frame in" value
    localparam logic [3:0] CNT_LAST = 4'(FRAME_W - 2);
    localparam logic [3:0] CNT_FULL = 4'(FRAME_W - 1);

    state_e               state;
    state_e               state_nxt;
    logic [3:0]           bit_cnt;
    logic [FRAME_W-2:0]   rx_shift;
    logic                 rd_addr_seen;
    logic                 rb_done;
    logic                 last_bit;
    logic                 rd_window;
    logic                 tx_load;
    logic                 tx_busy;
    logic                 tx_miso;

    assign last_bit  = is_frame_state(state) && (bit_cnt == CNT_LAST);
    assign rd_window = (state == READ_DATA) && (bit_cnt == CNT_FULL) && !bus.SS_n;
    assign tx_load   = rd_window && bus.tx_valid && !rb_done && !tx_busy;
    assign bus.MISO  = tx_miso;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; deselect wins from any state, payload states hold until deselect
    always_comb begin
        state_nxt = state;
        if (bus.SS_n) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = CHK_CMD;
                CHK_CMD: begin
                    if (!bus.MOSI) begin
                        state_nxt = WRITE;
                    end else if (rd_addr_seen) begin
                        state_nxt = READ_DATA;
                    end else begin
                        state_nxt = READ_ADD;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Frame completion, bit counter and read-sequencing flags; a frame whose bit 0 is
    // sampled together with deselect still completes
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= '0;
            bus.rx_valid <= 1'b0;
            bus.rx_data  <= '0;
            rd_addr_seen <= 1'b0;
            rb_done      <= 1'b0;
        end else begin
            bus.rx_valid <= last_bit;
            if (last_bit) begin
                bus.rx_data <= {rx_shift, bus.MOSI};
                if (state == READ_ADD) begin
                    rd_addr_seen <= 1'b1;
                end else if (state == READ_DATA) begin
                    rd_addr_seen <= 1'b0;
                end
            end
            if (bus.SS_n) begin
                bit_cnt <= '0;
                rb_done <= 1'b0;
            end else begin
                if (is_frame_state(state) && (bit_cnt != CNT_FULL)) begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (tx_load) begin
                    rb_done <= 1'b1;
                end
            end
        end
    end

    // Input shift register collects bits 9..1; bit 0 is merged straight into rx_data
    always_ff @(posedge clk) begin
        if ((state == CHK_CMD) || (is_frame_state(state) && (bit_cnt != CNT_FULL))) begin
            rx_shift <= {rx_shift[FRAME_W-3:0], bus.MOSI};
        end
    end

    spi_slave_ctrl_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.SS_n),
        .load    (tx_load),
        .tx_data (bus.tx_data),
        .miso    (tx_miso),
        .busy    (tx_busy)
    );

endmodule
